// File: rtl/calc_n_port.sv
// N-channel calculator: per-channel two-cycle request capture into a FIFO, round-robin
// arbitration into a shared 2-stage ALU pipeline, one registered response per pop.
module calc_n_port #(
    parameter int NUM_PORTS   = 4,
    parameter int DATA_W      = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                          c_clk,
    input  logic                          reset_n,
    input  logic [4*NUM_PORTS-1:0]        req_cmd_in,
    input  logic [DATA_W*NUM_PORTS-1:0]   req_data_in,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [DATA_W*NUM_PORTS-1:0]   out_data,
    output logic [2*NUM_PORTS-1:0]        out_resp
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int QW = $clog2(QUEUE_DEPTH);
    localparam int CW = QW + 1;
    localparam int SW = $clog2(DATA_W);
    localparam int EW = 4 + 2*DATA_W;

    logic [NUM_PORTS-1:0] pend;
    logic [3:0]           cmd_l  [NUM_PORTS];
    logic [DATA_W-1:0]    op1_l  [NUM_PORTS];
    logic [EW-1:0]        q_mem  [NUM_PORTS][QUEUE_DEPTH];
    logic [QW-1:0]        wr_ptr [NUM_PORTS];
    logic [QW-1:0]        rd_ptr [NUM_PORTS];
    logic [CW-1:0]        count  [NUM_PORTS];
    logic [NUM_PORTS-1:0] pop;
    logic                 gnt_valid;
    logic [PW-1:0]        gnt_idx;
    logic [PW-1:0]        rr_ptr;
    logic                 s1_valid;
    logic [PW-1:0]        s1_ch;
    logic [EW-1:0]        s1_ent;
    logic [3:0]           s1_cmd;
    logic [DATA_W-1:0]    s1_a;
    logic [DATA_W-1:0]    s1_b;
    logic [DATA_W:0]      sum;
    logic [1:0]           alu_resp;
    logic [DATA_W-1:0]    alu_data;

    // A slot is reserved for an operand2 cycle already in progress.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            req_ready[i] = !((count[i] == CW'(QUEUE_DEPTH)) ||
                             ((count[i] == CW'(QUEUE_DEPTH-1)) && pend[i]));
        end
    end

    always_comb begin
        int k;
        k         = 0;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        pop       = '0;
        for (int j = NUM_PORTS-1; j >= 0; j--) begin
            k = (int'(rr_ptr) + j) % NUM_PORTS;
            if (count[k] != '0) begin
                gnt_valid = 1'b1;
                gnt_idx   = PW'(k);
            end
        end
        if (gnt_valid) pop[gnt_idx] = 1'b1;
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                cmd_l[i]  <= '0;
                op1_l[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (pend[i]) begin
                    pend[i] <= 1'b0;
                end else if ((req_cmd_in[4*i +: 4] != 4'd0) && req_ready[i]) begin
                    pend[i]  <= 1'b1;
                    cmd_l[i] <= req_cmd_in[4*i +: 4];
                    op1_l[i] <= req_data_in[DATA_W*i +: DATA_W];
                end
                if (pend[i]) wr_ptr[i] <= wr_ptr[i] + QW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + QW'(1);
                if (pend[i] && !pop[i])      count[i] <= count[i] + CW'(1);
                else if (!pend[i] && pop[i]) count[i] <= count[i] - CW'(1);
            end
        end
    end

    always_ff @(posedge c_clk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (pend[i])
                q_mem[i][wr_ptr[i]] <= {cmd_l[i], op1_l[i], req_data_in[DATA_W*i +: DATA_W]};
        end
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr   <= '0;
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_ent   <= '0;
        end else begin
            s1_valid <= gnt_valid;
            s1_ch    <= gnt_idx;
            s1_ent   <= q_mem[gnt_idx][rd_ptr[gnt_idx]];
            if (gnt_valid)
                rr_ptr <= (gnt_idx == PW'(NUM_PORTS-1)) ? '0 : gnt_idx + PW'(1);
        end
    end

    assign s1_cmd = s1_ent[EW-1 -: 4];
    assign s1_a   = s1_ent[2*DATA_W-1 -: DATA_W];
    assign s1_b   = s1_ent[DATA_W-1:0];

    // Errors always carry zero data.
    always_comb begin
        sum      = {1'b0, s1_a} + {1'b0, s1_b};
        alu_resp = 2'd2;
        alu_data = '0;
        case (s1_cmd)
            4'd1: if (!sum[DATA_W]) begin
                alu_resp = 2'd1;
                alu_data = sum[DATA_W-1:0];
            end
            4'd2: if (s1_a >= s1_b) begin
                alu_resp = 2'd1;
                alu_data = s1_a - s1_b;
            end
            4'd5: begin
                alu_resp = 2'd1;
                alu_data = s1_a << s1_b[SW-1:0];
            end
            4'd6: begin
                alu_resp = 2'd1;
                alu_data = s1_a >> s1_b[SW-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge c_clk or negedge reset_n) begin
        if (!reset_n) begin
            out_resp <= '0;
            out_data <= '0;
        end else begin
            out_resp <= '0;
            out_data <= '0;
            if (s1_valid) begin
                out_resp[2*int'(s1_ch) +: 2]      <= alu_resp;
                out_data[DATA_W*int'(s1_ch) +: DATA_W] <= alu_data;
            end
        end
    end

endmodule

// File: tb/tb_calc_n_port.sv
// Self-checking bench for calc_n_port: directed cases plus randomized streaming, all
// cycle-compared against a queue-based reference model of the channel/arbiter/ALU behaviour.
module tb_calc_n_port;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int QD = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0]        cmd_v [NP];
    logic [DW-1:0]     dat_v [NP];
    logic [4*NP-1:0]   req_cmd;
    logic [DW*NP-1:0]  req_data;
    logic [NP-1:0]     req_ready;
    logic [DW*NP-1:0]  out_data;
    logic [2*NP-1:0]   out_resp;

    int n_chk = 0;
    int n_err = 0;

    for (genvar g = 0; g < NP; g++) begin : g_pack
        assign req_cmd[4*g +: 4]    = cmd_v[g];
        assign req_data[DW*g +: DW] = dat_v[g];
    end

    calc_n_port #(.NUM_PORTS(NP), .DATA_W(DW), .QUEUE_DEPTH(QD)) dut (
        .c_clk       (clk),
        .reset_n     (rst_n),
        .req_cmd_in  (req_cmd),
        .req_data_in (req_data),
        .req_ready   (req_ready),
        .out_data    (out_data),
        .out_resp    (out_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                    output logic [1:0] r, output logic [31:0] d);
        longint unsigned la, lb;
        la = 64'(a);
        lb = 64'(b);
        r  = 2'd2;
        d  = '0;
        case (c)
            4'd1: if (la + lb < 64'h1_0000_0000) begin r = 2'd1; d = 32'(la + lb); end
            4'd2: if (lb <= la) begin r = 2'd1; d = 32'(la - lb); end
            4'd5: begin r = 2'd1; d = 32'(la << (lb % 32)); end
            4'd6: begin r = 2'd1; d = 32'(la >> (lb % 32)); end
            default: ;
        endcase
    endfunction

    // Reference model: per-channel request lists, a fair scan pointer and a 2-deep result delay.
    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    req_t        mq [NP][$];
    bit          pend_m [NP];
    req_t        lat_m [NP];
    int          rr_m;
    bit          mid_v, out_v;
    int          mid_ch, out_ch;
    logic [1:0]  mid_r, out_r;
    logic [31:0] mid_d, out_d;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    int          drop_cnt = 0;

    always @(negedge clk) begin
        logic [2*NP-1:0] er;
        logic [DW*NP-1:0] ed;
        logic [NP-1:0] rdy;
        bit found;
        req_t e;
        int k;
        if (!rst_n) begin
            for (int ch = 0; ch < NP; ch++) begin
                mq[ch].delete();
                pend_m[ch] = 1'b0;
            end
            rr_m = 0; mid_v = 1'b0; out_v = 1'b0;
            acc_cnt = 0; rsp_cnt = 0;
            check("rst_resp", 128'(out_resp), 128'(0));
            check("rst_data", 128'(out_data), 128'(0));
            check("rst_ready", 128'(req_ready), 128'(4'hF));
        end else begin
            er = '0;
            ed = '0;
            if (out_v) begin
                er[2*out_ch +: 2]  = out_r;
                ed[DW*out_ch +: DW] = out_d;
            end
            for (int ch = 0; ch < NP; ch++)
                rdy[ch] = !((mq[ch].size() == QD) || (mq[ch].size() == QD-1 && pend_m[ch]));
            check("resp", 128'(out_resp), 128'(er));
            check("data", 128'(out_data), 128'(ed));
            check("ready", 128'(req_ready), 128'(rdy));
            for (int ch = 0; ch < NP; ch++)
                if (out_resp[2*ch +: 2] != 2'd0) rsp_cnt++;
            out_v = mid_v; out_ch = mid_ch; out_r = mid_r; out_d = mid_d;
            mid_v = 1'b0;
            found = 1'b0;
            for (int j = 0; j < NP; j++) begin
                k = (rr_m + j) % NP;
                if (!found && mq[k].size() > 0) begin
                    found = 1'b1;
                    e = mq[k].pop_front();
                    ref_alu(e.c, e.a, e.b, mid_r, mid_d);
                    mid_v = 1'b1;
                    mid_ch = k;
                    rr_m = (k + 1) % NP;
                end
            end
            for (int ch = 0; ch < NP; ch++) begin
                if (pend_m[ch]) begin
                    e = lat_m[ch];
                    e.b = dat_v[ch];
                    mq[ch].push_back(e);
                    pend_m[ch] = 1'b0;
                    acc_cnt++;
                end else if (cmd_v[ch] != 4'd0) begin
                    if (rdy[ch]) begin
                        pend_m[ch] = 1'b1;
                        lat_m[ch].c = cmd_v[ch];
                        lat_m[ch].a = dat_v[ch];
                        lat_m[ch].b = '0;
                    end else begin
                        drop_cnt++;
                    end
                end
            end
        end
    end

    task automatic run_one(input int ch, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] er, input logic [31:0] ed);
        int n;
        bit got;
        @(posedge clk); #1;
        cmd_v[ch] = c; dat_v[ch] = a;
        @(posedge clk); #1;
        cmd_v[ch] = 4'd0; dat_v[ch] = b;
        got = 1'b0;
        n = 0;
        while (!got && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (out_resp[2*ch +: 2] != 2'd0) got = 1'b1;
        end
        dat_v[ch] = '0;
        check("latency", 128'(n), 128'(3));
        check("dir_resp", 128'(out_resp[2*ch +: 2]), 128'(er));
        check("dir_data", 128'(out_data[DW*ch +: DW]), 128'(ed));
    endtask

    task automatic pulse_reset;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("prst_resp", 128'(out_resp), 128'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] cmd_tab [8];
        int n;
        cmd_tab[0] = 4'd1; cmd_tab[1] = 4'd1; cmd_tab[2] = 4'd1; cmd_tab[3] = 4'd2;
        cmd_tab[4] = 4'd5; cmd_tab[5] = 4'd6; cmd_tab[6] = 4'd3; cmd_tab[7] = 4'd1;
        rst_n = 1'b1;
        for (int ch = 0; ch < NP; ch++) begin
            cmd_v[ch] = '0;
            dat_v[ch] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        run_one(0, 4'd1, 32'h0000_0001, 32'h14FF_FFFE, 2'd1, 32'h14FF_FFFF);
        run_one(1, 4'd1, 32'hF000_0000, 32'hF000_0000, 2'd2, 32'h0);
        run_one(1, 4'd1, 32'h0, 32'h1FFF_FFFF, 2'd1, 32'h1FFF_FFFF);
        run_one(2, 4'd2, 32'd5, 32'd7, 2'd2, 32'h0);
        run_one(2, 4'd2, 32'd7, 32'd5, 2'd1, 32'd2);
        run_one(2, 4'd5, 32'd1, 32'd33, 2'd1, 32'd2);
        run_one(2, 4'd6, 32'h8000_0000, 32'd31, 2'd1, 32'd1);
        run_one(2, 4'd3, 32'd9, 32'd9, 2'd2, 32'h0);
        run_one(3, 4'd2, 32'd9, 32'd9, 2'd1, 32'h0);

        // Simultaneous requests from a fresh pointer come back in channel order.
        pulse_reset();
        @(posedge clk); #1;
        for (int ch = 0; ch < NP; ch++) begin cmd_v[ch] = 4'd1; dat_v[ch] = 32'(ch + 1); end
        @(posedge clk); #1;
        for (int ch = 0; ch < NP; ch++) begin cmd_v[ch] = 4'd0; dat_v[ch] = 32'(16 * (ch + 1)); end
        repeat (2) @(posedge clk);
        for (int k = 0; k < NP; k++) begin
            @(posedge clk); #1;
            check("rr_order", 128'(out_resp), 128'(8'h1 << (2*k)));
        end
        for (int ch = 0; ch < NP; ch++) dat_v[ch] = '0;

        // Saturating random traffic on every channel.
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NP; ch++) begin
                cmd_v[ch] = cmd_tab[$urandom_range(0, 7)];
                dat_v[ch] = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 64));
            end
        end
        @(posedge clk); #1;
        for (int ch = 0; ch < NP; ch++) begin cmd_v[ch] = '0; dat_v[ch] = '0; end
        repeat (40) @(posedge clk);
        #1;
        check("drops_seen", 128'(drop_cnt > 0), 128'(1));
        check("rsp_count", 128'(rsp_cnt), 128'(acc_cnt));

        // Reset while channel 3 has a backlog.
        n = 0;
        while (mq[3].size() < 3 && n < 60) begin
            @(posedge clk); #1;
            for (int ch = 0; ch < NP; ch++) begin
                cmd_v[ch] = 4'd1;
                dat_v[ch] = 32'($urandom_range(0, 1000));
            end
            n++;
        end
        check("ch3_fill", 128'(mq[3].size()), 128'(3));
        rst_n = 1'b0;
        for (int ch = 0; ch < NP; ch++) begin cmd_v[ch] = '0; dat_v[ch] = '0; end
        #1;
        check("rst_imm_resp", 128'(out_resp), 128'(0));
        check("rst_imm_data", 128'(out_data), 128'(0));
        check("rst_imm_ready", 128'(req_ready), 128'(4'hF));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        run_one(3, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5);
        repeat (4) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
